// File: rtl/reorder_buffer_pkg.sv
// Shared sizing constants and entry layout for the reorder buffer.
// Imported by the reorder buffer and by anything that decodes its indices.
package reorder_buffer_pkg;

    localparam int RoB_WIDTH    = 8;
    localparam int EX_RoB_WIDTH = 9;
    localparam int RoB_SIZE     = 1 << RoB_WIDTH;
    localparam int EX_REG_WIDTH = 6;

    // Extended index with MSB set marks "no dependency".
    localparam logic [EX_RoB_WIDTH-1:0] NON_DEP = 9'b1_0000_0000;
    localparam logic [EX_REG_WIDTH-1:0] NON_REG = 6'b100000;

    typedef struct packed {
        logic                    busy;
        logic                    ready;
        logic [EX_REG_WIDTH-1:0] rd;
        logic [31:0]             value;
        logic                    is_branch;
        logic                    pred_taken;
        logic                    taken;
        logic [31:0]             alt_pc;
    } rob_entry_t;

endpackage

// File: rtl/reorder_buffer.sv
// Circular in-order retirement buffer: allocates at dispatch, records CDB
// writebacks, commits the head to the register file and flushes on mispredict.
module reorder_buffer
    import reorder_buffer_pkg::*;
(
    input  logic                    Sys_clk,
    input  logic                    Sys_rst,
    input  logic                    Sys_rdy,
    input  logic                    DPRoB_en,
    input  logic [EX_REG_WIDTH-1:0] DPRoB_rd,
    input  logic                    DPRoB_is_branch,
    input  logic                    DPRoB_pred_taken,
    input  logic [31:0]             DPRoB_alt_pc,
    output logic                    RoBDP_full,
    output logic [RoB_WIDTH-1:0]    RoBDP_index,
    input  logic                    CDBRoB_en,
    input  logic [RoB_WIDTH-1:0]    CDBRoB_index,
    input  logic [31:0]             CDBRoB_value,
    input  logic                    CDBRoB_taken,
    output logic                    RoBRF_en,
    output logic [RoB_WIDTH-1:0]    RoBRF_RoB_index,
    output logic [EX_REG_WIDTH-1:0] RoBRF_rd,
    output logic [31:0]             RoBRF_value,
    output logic                    RoBRF_pre_judge,
    output logic [31:0]             RoBIF_pc
);

    localparam logic [RoB_WIDTH:0]   FULL_CNT = (RoB_WIDTH + 1)'(RoB_SIZE);
    localparam logic [RoB_WIDTH-1:0] IDX_ONE  = RoB_WIDTH'(1);

    rob_entry_t entry [RoB_SIZE];

    logic [RoB_WIDTH-1:0] head;
    logic [RoB_WIDTH-1:0] tail;
    logic [RoB_WIDTH:0]   count;
    logic [RoB_WIDTH:0]   count_next;

    rob_entry_t head_e;
    logic       alloc;
    logic       commit;
    logic       mispredict;

    assign head_e      = entry[head];
    assign RoBDP_full  = (count == FULL_CNT);
    assign RoBDP_index = tail;

    assign alloc      = DPRoB_en && !RoBDP_full;
    assign commit     = head_e.busy && head_e.ready;
    assign mispredict = commit && head_e.is_branch &&
                        (head_e.taken != head_e.pred_taken);

    always_comb begin
        count_next = count;
        count_next = count_next + (RoB_WIDTH + 1)'(alloc);
        count_next = count_next - (RoB_WIDTH + 1)'(commit);
    end

    always_ff @(posedge Sys_clk) begin
        if (Sys_rst) begin
            head            <= '0;
            tail            <= '0;
            count           <= '0;
            RoBRF_en        <= 1'b0;
            RoBRF_RoB_index <= '0;
            RoBRF_rd        <= NON_REG;
            RoBRF_value     <= '0;
            RoBRF_pre_judge <= 1'b1;
            RoBIF_pc        <= '0;
            for (int i = 0; i < RoB_SIZE; i++) begin
                entry[i].busy  <= 1'b0;
                entry[i].ready <= 1'b0;
            end
        end else if (Sys_rdy) begin
            RoBRF_en        <= commit;
            RoBRF_pre_judge <= !mispredict;

            if (commit) begin
                RoBRF_RoB_index  <= head;
                RoBRF_rd         <= head_e.is_branch ? NON_REG : head_e.rd;
                RoBRF_value      <= head_e.value;
                entry[head].busy <= 1'b0;
            end

            if (mispredict) begin
                // Everything younger than the branch is wrong-path work.
                RoBIF_pc <= head_e.alt_pc;
                head     <= '0;
                tail     <= '0;
                count    <= '0;
                for (int i = 0; i < RoB_SIZE; i++) begin
                    entry[i].busy <= 1'b0;
                end
            end else begin
                if (commit) begin
                    head <= head + IDX_ONE;
                end

                if (alloc) begin
                    entry[tail] <= '{
                        busy:       1'b1,
                        ready:      1'b0,
                        rd:         DPRoB_rd,
                        value:      32'd0,
                        is_branch:  DPRoB_is_branch,
                        pred_taken: DPRoB_pred_taken,
                        taken:      1'b0,
                        alt_pc:     DPRoB_alt_pc
                    };
                    tail <= tail + IDX_ONE;
                end

                if (CDBRoB_en && entry[CDBRoB_index].busy) begin
                    entry[CDBRoB_index].ready <= 1'b1;
                    entry[CDBRoB_index].value <= CDBRoB_value;
                    entry[CDBRoB_index].taken <= CDBRoB_taken;
                end

                count <= count_next;
            end
        end
    end

endmodule
